uart_rx_frontend: RTL and testbench
===================================

UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per serial bit (100 MHz / 115200); legal range 8..65535.
REQ-002 The block SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-005 The block SHALL have port io_data_valid, output, 1, one-cycle pulse; a received byte is on io_data_packet.
REQ-006 The block SHALL have port io_data_packet, output, 8, last received byte, LSB first on the line.
REQ-007 The block SHALL have port framing_error, output, 1, one-cycle pulse; stop bit sampled low.
REQ-008 The block SHALL have port parity_error, output, 1, one-cycle pulse; parity mismatch.
REQ-009 The block SHALL have port rx_busy, output, 1, high in every state other than IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-011 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
REQ-012 IDLE -> START SHALL occur on the first cycle rx_s is low; the baud counter clears to 0 on that cycle.
REQ-013 In START, at count CLKS_PER_BIT/2 (integer divide), rx_s high SHALL return to IDLE (glitch, no pulse); rx_s low -> DATA with the counter cleared.
REQ-014 In DATA, PARITY and STOP, each bit SHALL be sampled when the counter reaches CLKS_PER_BIT-1, then the counter clears; this sampling falls mid-bit.
REQ-015 DATA SHALL shift 8 bits LSB first using a 3-bit bit index; after bit 7 -> PARITY if the macro is defined, else STOP.
REQ-016 STOP sample high with no parity error SHALL load io_data_packet and pulse io_data_valid for exactly one cycle, on the cycle after the sample edge -> IDLE.
REQ-017 STOP sample low SHALL pulse framing_error for one cycle with no io_data_valid; io_data_packet is unchanged -> WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL stay until rx_s is high, then -> IDLE; a break condition (line held low) produces exactly one framing_error.
REQ-019 io_data_packet SHALL hold its value between frames; the block has no overrun detection, because the consumer accepts every pulse.
REQ-020 Back-to-back frames SHALL be accepted: a falling edge on the first IDLE cycle after STOP starts a new frame.
REQ-021 Error pulses and io_data_valid SHALL be mutually exclusive in any cycle.

Reset
REQ-022 While reset_n=0 at a clk edge, the block SHALL enter IDLE, clear counter and bit index, set io_data_packet=0x00, and set io_data_valid, framing_error and parity_error to 0.
REQ-023 Reset SHALL set the synchronizer flops to 1 (idle line).
REQ-024 Reset mid-frame SHALL discard the partial byte with no pulse; if rx is low on release, that counts as a new start edge.

Configuration
REQ-025 With macro UART_RX_PARITY_EN defined, the block SHALL expect one even-parity bit after bit 7 and sample it in PARITY.
REQ-026 On a mismatch it SHALL still sample STOP; a high stop bit then pulses parity_error with no io_data_valid, and a low stop bit pulses only framing_error.
REQ-027 Without UART_RX_PARITY_EN, the PARITY state SHALL be absent, the frame SHALL be 8N1, and parity_error SHALL be tied 0.

Verification (CLKS_PER_BIT=16)
REQ-028 Frame 0xA5, 8N1 -> single io_data_valid pulse; io_data_packet=0xA5; rx_busy falls the same cycle; no error pulses.
REQ-029 rx low for 4 cycles, then high -> return to IDLE within 8 cycles of the edge; no pulses; io_data_packet unchanged.
REQ-030 Frame 0x3C with stop bit 0, line held low 40 cycles, then high -> exactly one framing_error; no valid; next frame 0x01 received correctly.
REQ-031 reset_n=0 for 1 cycle during bit 4 of a 0xFF frame -> no pulse; the following 0x5A frame is received as 0x5A.
REQ-032 Three consecutive frames 0x00, 0xFF, 0x81 with no idle gap -> three valid pulses in order with the correct bytes.
REQ-033 With UART_RX_PARITY_EN defined, 0x03 with parity bit 1 -> parity_error pulse and no valid; 0x03 with parity 0 -> valid, io_data_packet=0x03.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// UART receive front end: 2-flop synchronizer, mid-bit sampling FSM, 8N1 framing.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits (8E1).
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic       io_data_valid,
    output logic [7:0] io_data_packet,
    output logic       framing_error,
    output logic       parity_error,
    output logic       rx_busy,
    output logic [2:0] state_dbg
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_s_q, rx_s_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        par_ok;
    logic        sample;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic perr_q, perr_d;
    assign par_ok = ~par_bad_q;
`else
    assign par_ok = 1'b1;
`endif

    assign sample = (cnt_q == LAST_CNT);

    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d     = 16'd0;
                bit_idx_d = 3'd0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                // Re-check the line half a bit in; a high line here was only a glitch.
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = 16'd0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    cnt_d     = 16'd0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample) begin
                    cnt_d     = 16'd0;
                    par_bad_d = rx_s_q ^ (^shift_q);
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (sample) begin
                    cnt_d = 16'd0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                        if (par_ok) begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
`ifdef UART_RX_PARITY_EN
                        else perr_d = 1'b1;
`endif
                    end else begin
                        // Low stop bit: report once, then wait out any break.
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = 16'd0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign io_data_valid  = valid_q;
    assign io_data_packet = data_q;
    assign framing_error  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error   = perr_q;
`else
    assign parity_error   = 1'b0;
`endif
    assign rx_busy        = (state_q != IDLE);
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at CLKS_PER_BIT=16; a pulse monitor feeds the scoreboard.
module tb_uart_rx_frontend;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int EXP_PERR = 1;
`else
    localparam int EXP_PERR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       io_data_valid;
    logic [7:0] io_data_packet;
    logic       framing_error;
    logic       parity_error;
    logic       rx_busy;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    logic busy_prev = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx            (rx),
        .io_data_valid (io_data_valid),
        .io_data_packet(io_data_packet),
        .framing_error (framing_error),
        .parity_error  (parity_error),
        .rx_busy       (rx_busy),
        .state_dbg     (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_head(input logic [7:0] b, input logic par_flip);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        tick(CPB);
`else
        if (par_flip) $display("note: parity flip has no effect in 8N1 build");
`endif
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip);
        send_head(b, par_flip);
        rx = 1'b1;
        tick(CPB);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        tick(n);
    endtask

    // scoreboard: every pulse is checked here, sampled mid-cycle
    always @(negedge clk) begin
        if (reset_n) begin
            if (io_data_valid || framing_error || parity_error)
                check("pulse_exclusive",
                      32'(io_data_valid) + 32'(framing_error) + 32'(parity_error), 32'd1);
            if (io_data_valid) begin
                valid_cnt++;
                check("busy_low_at_valid", 32'(rx_busy), 32'd0);
                check("busy_before_valid", 32'(busy_prev), 32'd1);
                check("valid_was_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("rx_byte", 32'(io_data_packet), 32'(exp_q.pop_front()));
            end
            if (framing_error) ferr_cnt++;
            if (parity_error) perr_cnt++;
        end
        busy_prev = rx_busy;
    end

    initial begin
        int v0, f0, p0, n;

        // reset state
        reset_n = 1'b0;
        rx = 1'b1;
        tick(4);
        check("rst_packet", 32'(io_data_packet), 32'h00);
        check("rst_valid", 32'(io_data_valid), 32'd0);
        check("rst_ferr", 32'(framing_error), 32'd0);
        check("rst_perr", 32'(parity_error), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        reset_n = 1'b1;
        idle(8);

        // single frame 0xA5
        v0 = valid_cnt; f0 = ferr_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0);
        idle(2 * CPB);
        check("a5_valid_count", 32'(valid_cnt - v0), 32'd1);
        check("a5_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("a5_packet", 32'(io_data_packet), 32'hA5);

        // 4-cycle glitch on the line
        v0 = valid_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            n++;
            if (!rx_busy) break;
        end
        check("glitch_idle_within_8", 32'(n <= 8), 32'd1);
        idle(2 * CPB);
        check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("glitch_packet_held", 32'(io_data_packet), 32'hA5);

        // 0x3C with low stop bit, line held low for 40 cycles
        v0 = valid_cnt; f0 = ferr_cnt;
        send_head(8'h3C, 1'b0);
        rx = 1'b0;
        tick(40);
        idle(2 * CPB);
        check("break_one_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("break_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("break_packet_held", 32'(io_data_packet), 32'hA5);
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b0);
        idle(2 * CPB);
        check("after_break_valid", 32'(valid_cnt - v0), 32'd1);
        check("after_break_packet", 32'(io_data_packet), 32'h01);

        // reset in the middle of bit 4 of a 0xFF frame
        v0 = valid_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(4 * CPB + CPB / 2);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("midrst_packet_cleared", 32'(io_data_packet), 32'h00);
        check("midrst_idle", 32'(rx_busy), 32'd0);
        idle(6 * CPB);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0);
        idle(2 * CPB);
        check("midrst_one_valid", 32'(valid_cnt - v0), 32'd1);
        check("midrst_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("midrst_packet", 32'(io_data_packet), 32'h5A);

        // back-to-back frames, no idle gap
        v0 = valid_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h81);
        send_frame(8'h00, 1'b0);
        send_frame(8'hFF, 1'b0);
        send_frame(8'h81, 1'b0);
        idle(2 * CPB);
        check("b2b_valid_count", 32'(valid_cnt - v0), 32'd3);
        check("b2b_last_packet", 32'(io_data_packet), 32'h81);

`ifdef UART_RX_PARITY_EN
        // 0x03 with wrong parity, then with correct parity
        v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h03, 1'b1);
        idle(2 * CPB);
        check("par_bad_perr", 32'(perr_cnt - p0), 32'd1);
        check("par_bad_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("par_bad_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b0);
        idle(2 * CPB);
        check("par_ok_valid", 32'(valid_cnt - v0), 32'd1);
        check("par_ok_packet", 32'(io_data_packet), 32'h03);
`else
        p0 = perr_cnt;
        check("no_parity_port_activity", 32'(p0), 32'd0);
`endif

        check("parity_error_total", 32'(perr_cnt), 32'(EXP_PERR));
        check("all_expected_seen", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
